pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
- Pipeline-register bank for the 5-stage MIPS core: F/D, D/E, E/M and M/W registers in one block.
- Carries instruction word, PC and a Tnew countdown per stage.
- Produces the D/E/M/W instruction words consumed by the forwarding unit and the hazard unit.
- Implements the stall/bubble rule: freeze F and D, inject a NOP into E, let E/M/W drain.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded into every stage PC register on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble and held on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge.
- stall  in  1  from hazard unit; 1 = freeze F/D, bubble E.
- F_instr  in  32  fetched instruction.
- F_pc  in  32  PC of F_instr.
- D_tnew_in  in  2  Tnew of the current D instruction at E entry (decoded externally: calc=1, load=2, jal/none=0).
- D_instr  out  32  F/D register instruction.
- D_pc  out  32  F/D register PC.
- E_instr  out  32  D/E register instruction.
- E_pc  out  32  D/E register PC.
- E_tnew  out  2  Tnew of E instruction.
- M_instr  out  32  E/M register instruction.
- M_pc  out  32  E/M register PC.
- M_tnew  out  2  Tnew of M instruction.
- W_instr  out  32  M/W register instruction.
- W_pc  out  32  M/W register PC.

Behaviour:
- Reset (reset==0 at a clk edge): all *_instr = NOP_INSTR, all *_pc = RESET_PC, E_tnew = M_tnew = 0. Reset overrides stall.
- Normal advance (reset==1, stall==0), one rising edge per stage:
  - D <= F_instr/F_pc.
  - E <= D_instr/D_pc, E_tnew <= D_tnew_in.
  - M <= E, M_tnew <= sat_dec(E_tnew).
  - W <= M.
- Latency: an F_instr presented at edge n appears on D_instr after n, E_instr after n+1, M_instr after n+2, W_instr after n+3.
- sat_dec(x) = (x==0) ? 0 : x-1, 2-bit. Never wraps 0 -> 3.
- Stall (reset==1, stall==1):
  - D_instr/D_pc hold.
  - E_instr <= NOP_INSTR, E_pc <= D_pc (bubble keeps PC for debug tracing), E_tnew <= 0.
  - M and W advance normally from E and M.
  - F_instr is ignored. Upstream PC freeze is the hazard unit's job.
- Consecutive stalls: D holds indefinitely; E receives a NOP every stalled cycle.
- Stall released: the held D instruction enters E on the next edge, with the D_tnew_in present at that edge.
- Bubble in M/W: NOP_INSTR with tnew 0. Downstream forwarding logic treats it as non-writing.
- All outputs are registered directly; no combinational path from any input to any output.
- stall and D_tnew_in are sampled only at clk edges. Glitches between edges have no effect.

Optional Feature:
PIPE_STATS_EN
- Defined:
  - Adds outputs stall_cnt[31:0] and retire_cnt[31:0], both reset to 0.
  - stall_cnt increments on every non-reset edge with stall==1.
  - retire_cnt increments on every non-reset edge where W_instr != NOP_INSTR, i.e. counts W-stage completions.
  - Both wrap 32'hFFFF_FFFF -> 0.
- Not defined: neither port nor either counter exists; the block is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 edges with stall=1, F_instr=32'h2008_0001 -> all instr = 0, all pc = 32'h0000_3000, E_tnew = M_tnew = 0.
- Straight flow: 4 edges with F_instr=A,B,C,D (A=32'h3c01_1234), F_pc=3000,3004,...
  - After edge 4: D=D, E=C, M=B, W=A.
  - W_pc = 32'h3000.
- Tnew decay: lw enters E with D_tnew_in=2.
  - E_tnew = 2, then M_tnew = 1.
  - A calc with 1 -> M_tnew = 0.
  - D_tnew_in=0 -> M_tnew = 0 (no wrap to 3).
- Single stall: pipeline holds lw in E, add in D; assert stall for 1 edge.
  - D still add; E = 0 with E_tnew = 0; M = lw.
  - Next edge (stall=0): E = add.
- Triple stall: 3 consecutive stall edges -> D unchanged throughout, three NOPs enter E, W receives them on later edges.
- Reset mid-stream: reset=0 while stall=1 and pipeline full -> all stages cleared to NOP / RESET_PC on that edge.
- With PIPE_STATS_EN: 5 instructions, 2 stall cycles, 10 edges -> stall_cnt = 2, retire_cnt equals the count of non-NOP words seen on W.

Source files
------------

// File: rtl/pipe_stage_regs_if.sv
// Handshake bundle between the pipeline register bank and the hazard/forwarding logic.
// With PIPE_STATS_EN defined, the bundle also carries the stall and retire counters.
interface pipe_stage_regs_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TNEW_W = 2;

    logic              stall;
    logic [XLEN-1:0]   F_instr;
    logic [XLEN-1:0]   F_pc;
    logic [TNEW_W-1:0] D_tnew_in;

    logic [XLEN-1:0]   D_instr;
    logic [XLEN-1:0]   D_pc;
    logic [XLEN-1:0]   E_instr;
    logic [XLEN-1:0]   E_pc;
    logic [TNEW_W-1:0] E_tnew;
    logic [XLEN-1:0]   M_instr;
    logic [XLEN-1:0]   M_pc;
    logic [TNEW_W-1:0] M_tnew;
    logic [XLEN-1:0]   W_instr;
    logic [XLEN-1:0]   W_pc;
`ifdef PIPE_STATS_EN
    logic [XLEN-1:0]   stall_cnt;
    logic [XLEN-1:0]   retire_cnt;
`endif

    modport master (
        output stall, F_instr, F_pc, D_tnew_in,
        input  D_instr, D_pc, E_instr, E_pc, E_tnew,
        input  M_instr, M_pc, M_tnew, W_instr, W_pc
`ifdef PIPE_STATS_EN
        , input stall_cnt, retire_cnt
`endif
    );

    modport slave (
        input  stall, F_instr, F_pc, D_tnew_in,
        output D_instr, D_pc, E_instr, E_pc, E_tnew,
        output M_instr, M_pc, M_tnew, W_instr, W_pc
`ifdef PIPE_STATS_EN
        , output stall_cnt, retire_cnt
`endif
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// F/D, D/E, E/M, M/W pipeline registers with stall/bubble handling and Tnew decay.
// Optional PIPE_STATS_EN adds free-running stall and retire counters.
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_regs_if.slave  bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TNEW_W = 2;

    // Tnew counts down toward zero and saturates there.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == TNEW_W'(0)) ? TNEW_W'(0) : x - TNEW_W'(1);
    endfunction

    logic [XLEN-1:0]   d_instr_q, d_instr_d;
    logic [XLEN-1:0]   d_pc_q,    d_pc_d;
    logic [XLEN-1:0]   e_instr_q, e_instr_d;
    logic [XLEN-1:0]   e_pc_q,    e_pc_d;
    logic [TNEW_W-1:0] e_tnew_q,  e_tnew_d;
    logic [XLEN-1:0]   m_instr_q, m_instr_d;
    logic [XLEN-1:0]   m_pc_q,    m_pc_d;
    logic [TNEW_W-1:0] m_tnew_q,  m_tnew_d;
    logic [XLEN-1:0]   w_instr_q, w_instr_d;
    logic [XLEN-1:0]   w_pc_q,    w_pc_d;

    // Next-state for every stage; M and W always drain, F/D and D/E obey stall.
    always_comb begin
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        e_instr_d = e_instr_q;
        e_pc_d    = e_pc_q;
        e_tnew_d  = e_tnew_q;

        m_instr_d = e_instr_q;
        m_pc_d    = e_pc_q;
        m_tnew_d  = sat_dec(e_tnew_q);
        w_instr_d = m_instr_q;
        w_pc_d    = m_pc_q;

        if (bus.stall) begin
            // Bubble keeps the held D PC so traces still show where it came from.
            e_instr_d = NOP_INSTR;
            e_pc_d    = d_pc_q;
            e_tnew_d  = TNEW_W'(0);
        end else begin
            d_instr_d = bus.F_instr;
            d_pc_d    = bus.F_pc;
            e_instr_d = d_instr_q;
            e_pc_d    = d_pc_q;
            e_tnew_d  = bus.D_tnew_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_instr_q <= NOP_INSTR;
            d_pc_q    <= RESET_PC;
            e_instr_q <= NOP_INSTR;
            e_pc_q    <= RESET_PC;
            e_tnew_q  <= TNEW_W'(0);
            m_instr_q <= NOP_INSTR;
            m_pc_q    <= RESET_PC;
            m_tnew_q  <= TNEW_W'(0);
            w_instr_q <= NOP_INSTR;
            w_pc_q    <= RESET_PC;
        end else begin
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            e_instr_q <= e_instr_d;
            e_pc_q    <= e_pc_d;
            e_tnew_q  <= e_tnew_d;
            m_instr_q <= m_instr_d;
            m_pc_q    <= m_pc_d;
            m_tnew_q  <= m_tnew_d;
            w_instr_q <= w_instr_d;
            w_pc_q    <= w_pc_d;
        end
    end

    assign bus.D_instr = d_instr_q;
    assign bus.D_pc    = d_pc_q;
    assign bus.E_instr = e_instr_q;
    assign bus.E_pc    = e_pc_q;
    assign bus.E_tnew  = e_tnew_q;
    assign bus.M_instr = m_instr_q;
    assign bus.M_pc    = m_pc_q;
    assign bus.M_tnew  = m_tnew_q;
    assign bus.W_instr = w_instr_q;
    assign bus.W_pc    = w_pc_q;

`ifdef PIPE_STATS_EN
    logic [XLEN-1:0] stall_cnt_q,  stall_cnt_d;
    logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;

    // Retire counts the instruction sitting in W at the edge; both wrap naturally.
    always_comb begin
        stall_cnt_d  = stall_cnt_q  + XLEN'(bus.stall);
        retire_cnt_d = retire_cnt_q + XLEN'(w_instr_q != NOP_INSTR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q  <= XLEN'(0);
            retire_cnt_q <= XLEN'(0);
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Table-driven bench for pipe_stage_regs with an in-order retirement scoreboard on W.
module tb_pipe_stage_regs;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    localparam logic [31:0] IA = 32'h3c01_1234;
    localparam logic [31:0] IB = 32'h3421_5678;
    localparam logic [31:0] IC = 32'h8c22_0000;
    localparam logic [31:0] ID = 32'h0022_1820;
    localparam logic [31:0] IX = 32'h2002_0005;
    localparam logic [31:0] IY = 32'h2003_0007;
    localparam logic [31:0] IZ = 32'h2004_0009;

    typedef struct {
        logic        stall;
        logic [31:0] f_instr;
        logic [31:0] f_pc;
        logic [1:0]  tnew_in;
        logic [31:0] d_instr;
        logic [31:0] d_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [1:0]  e_tnew;
        logic [31:0] m_instr;
        logic [31:0] m_pc;
        logic [1:0]  m_tnew;
        logic [31:0] w_instr;
        logic [31:0] w_pc;
    } vec_t;

    logic clk;
    logic reset;
    pipe_stage_regs_if bus ();

    pipe_stage_regs #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] sbq[$];
    vec_t vecs[$];
    int stall_exp  = 0;
    int retire_exp = 0;
    bit prev_ret   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input logic st, input logic [31:0] fi, input logic [31:0] fp,
                       input logic [1:0] tn,
                       input logic [31:0] di, input logic [31:0] dp,
                       input logic [31:0] ei, input logic [31:0] ep, input logic [1:0] et,
                       input logic [31:0] mi, input logic [31:0] mp, input logic [1:0] mt,
                       input logic [31:0] wi, input logic [31:0] wp);
        vec_t v;
        v.stall = st; v.f_instr = fi; v.f_pc = fp; v.tnew_in = tn;
        v.d_instr = di; v.d_pc = dp; v.e_instr = ei; v.e_pc = ep; v.e_tnew = et;
        v.m_instr = mi; v.m_pc = mp; v.m_tnew = mt; v.w_instr = wi; v.w_pc = wp;
        vecs.push_back(v);
    endtask

    // Drive one edge, then update the stats model and retire-check W.
    task automatic step(input logic rst_v, input logic st, input logic [31:0] fi,
                        input logic [31:0] fp, input logic [1:0] tn);
        logic [63:0] e;
        reset         = rst_v;
        bus.stall     = st;
        bus.F_instr   = fi;
        bus.F_pc      = fp;
        bus.D_tnew_in = tn;
        if (rst_v && !st && fi != NOP) sbq.push_back({fi, fp});
        @(posedge clk);
        @(negedge clk);
        if (!rst_v) begin
            sbq.delete();
            stall_exp  = 0;
            retire_exp = 0;
            prev_ret   = 1'b0;
        end else begin
            stall_exp  += int'(st);
            retire_exp += int'(prev_ret);
            prev_ret   = 1'b0;
        end
        if (bus.W_instr !== NOP) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got W %h expected no retirement", bus.W_instr);
            end else begin
                e = sbq.pop_front();
                check("sb_w_instr", bus.W_instr, e[63:32]);
                check("sb_w_pc", bus.W_pc, e[31:0]);
                prev_ret = 1'b1;
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " D_instr"}, bus.D_instr, NOP);
        check({tag, " E_instr"}, bus.E_instr, NOP);
        check({tag, " M_instr"}, bus.M_instr, NOP);
        check({tag, " W_instr"}, bus.W_instr, NOP);
        check({tag, " D_pc"}, bus.D_pc, RST_PC);
        check({tag, " E_pc"}, bus.E_pc, RST_PC);
        check({tag, " M_pc"}, bus.M_pc, RST_PC);
        check({tag, " W_pc"}, bus.W_pc, RST_PC);
        check({tag, " E_tnew"}, 32'(bus.E_tnew), 32'd0);
        check({tag, " M_tnew"}, 32'(bus.M_tnew), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; bus.stall = 1'b1; bus.F_instr = 32'h2008_0001;
        bus.F_pc = 32'h0000_4000; bus.D_tnew_in = 2'd2;

        //   st fi  fp            tn  | D            | E                  | M                  | W
        add(0, IA, 32'h3000, 0,  IA, 32'h3000,  NOP, 32'h3000, 0,  NOP, 32'h3000, 0,  NOP, 32'h3000);
        add(0, IB, 32'h3004, 1,  IB, 32'h3004,  IA,  32'h3000, 1,  NOP, 32'h3000, 0,  NOP, 32'h3000);
        add(0, IC, 32'h3008, 1,  IC, 32'h3008,  IB,  32'h3004, 1,  IA,  32'h3000, 0,  NOP, 32'h3000);
        add(0, ID, 32'h300c, 2,  ID, 32'h300c,  IC,  32'h3008, 2,  IB,  32'h3004, 0,  IA,  32'h3000);
        add(1, IX, 32'h3010, 1,  ID, 32'h300c,  NOP, 32'h300c, 0,  IC,  32'h3008, 1,  IB,  32'h3004);
        add(0, IX, 32'h3010, 1,  IX, 32'h3010,  ID,  32'h300c, 1,  NOP, 32'h300c, 0,  IC,  32'h3008);
        add(0, IY, 32'h3014, 0,  IY, 32'h3014,  IX,  32'h3010, 0,  ID,  32'h300c, 0,  NOP, 32'h300c);
        add(1, IZ, 32'h3018, 1,  IY, 32'h3014,  NOP, 32'h3014, 0,  IX,  32'h3010, 0,  ID,  32'h300c);
        add(1, IZ, 32'h3018, 1,  IY, 32'h3014,  NOP, 32'h3014, 0,  NOP, 32'h3014, 0,  IX,  32'h3010);
        add(1, IZ, 32'h3018, 1,  IY, 32'h3014,  NOP, 32'h3014, 0,  NOP, 32'h3014, 0,  NOP, 32'h3014);
        add(0, IZ, 32'h3018, 2,  IZ, 32'h3018,  IY,  32'h3014, 2,  NOP, 32'h3014, 0,  NOP, 32'h3014);
        add(0, NOP, 32'h301c, 1, NOP, 32'h301c, IZ,  32'h3018, 1,  IY,  32'h3014, 1,  NOP, 32'h3014);
        add(0, NOP, 32'h3020, 0, NOP, 32'h3020, NOP, 32'h301c, 0,  IZ,  32'h3018, 0,  IY,  32'h3014);
        add(0, NOP, 32'h3024, 0, NOP, 32'h3024, NOP, 32'h3020, 0,  NOP, 32'h301c, 0,  IZ,  32'h3018);
        add(0, NOP, 32'h3028, 0, NOP, 32'h3028, NOP, 32'h3024, 0,  NOP, 32'h3020, 0,  NOP, 32'h301c);

        @(negedge clk);
        step(1'b0, 1'b1, 32'h2008_0001, 32'h0000_4000, 2'd2);
        step(1'b0, 1'b1, 32'h2008_0001, 32'h0000_4000, 2'd2);
        check_cleared("reset");

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].stall, vecs[i].f_instr, vecs[i].f_pc, vecs[i].tnew_in);
            check($sformatf("v%0d D_instr", i), bus.D_instr, vecs[i].d_instr);
            check($sformatf("v%0d D_pc", i), bus.D_pc, vecs[i].d_pc);
            check($sformatf("v%0d E_instr", i), bus.E_instr, vecs[i].e_instr);
            check($sformatf("v%0d E_pc", i), bus.E_pc, vecs[i].e_pc);
            check($sformatf("v%0d E_tnew", i), 32'(bus.E_tnew), 32'(vecs[i].e_tnew));
            check($sformatf("v%0d M_instr", i), bus.M_instr, vecs[i].m_instr);
            check($sformatf("v%0d M_pc", i), bus.M_pc, vecs[i].m_pc);
            check($sformatf("v%0d M_tnew", i), 32'(bus.M_tnew), 32'(vecs[i].m_tnew));
            check($sformatf("v%0d W_instr", i), bus.W_instr, vecs[i].w_instr);
            check($sformatf("v%0d W_pc", i), bus.W_pc, vecs[i].w_pc);
        end
        check("table sb_drained", 32'(sbq.size()), 32'd0);
`ifdef PIPE_STATS_EN
        step(1'b1, 1'b0, NOP, 32'h302c, 2'd0);
        check("stall_cnt", bus.stall_cnt, 32'(stall_exp));
        check("retire_cnt", bus.retire_cnt, 32'(retire_exp));
`endif

        // Fill with three instructions, then reset while stalled.
        step(1'b1, 1'b0, 32'h2010_0011, 32'h3100, 2'd1);
        step(1'b1, 1'b0, 32'h2011_0022, 32'h3104, 2'd1);
        step(1'b1, 1'b0, 32'h2012_0033, 32'h3108, 2'd1);
        check("prefill E_instr", bus.E_instr, 32'h2011_0022);
        check("prefill M_instr", bus.M_instr, 32'h2010_0011);
        step(1'b0, 1'b1, 32'h2013_0044, 32'h310c, 2'd2);
        check_cleared("midreset");
`ifdef PIPE_STATS_EN
        check("midreset stall_cnt", bus.stall_cnt, 32'd0);
        check("midreset retire_cnt", bus.retire_cnt, 32'd0);
`endif

        // Short stream with two stalls to exercise counters and retirement again.
        step(1'b1, 1'b0, 32'h2020_0001, 32'h3200, 2'd0);
        step(1'b1, 1'b0, 32'h2020_0002, 32'h3204, 2'd1);
        step(1'b1, 1'b1, 32'h2020_0003, 32'h3208, 2'd1);
        step(1'b1, 1'b0, 32'h2020_0003, 32'h3208, 2'd1);
        step(1'b1, 1'b1, 32'h2020_0004, 32'h320c, 2'd1);
        step(1'b1, 1'b0, 32'h2020_0004, 32'h320c, 2'd1);
        step(1'b1, 1'b0, 32'h2020_0005, 32'h3210, 2'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, NOP, 32'h3214 + 32'(4 * k), 2'd1);
        check("final sb_drained", 32'(sbq.size()), 32'd0);
`ifdef PIPE_STATS_EN
        check("final stall_cnt", bus.stall_cnt, 32'(stall_exp));
        check("final retire_cnt", bus.retire_cnt, 32'(retire_exp));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
